reg_writeback: RTL and testbench

Register-file write initiator for the RV32 core: accepts retiring results (destination index plus 32-bit value) from the execute/memory side over a valid/ready handshake, buffers them in order, and drives the `registers` write port (`A3`/`WD3`/`WE3`). It sits between the last pipeline stage and the register file. It also supplies forwarding for the two read addresses so that values still pending in the buffer are never read stale.

---
 rtl/reg_writeback_pkg.sv | 16 +
 rtl/reg_writeback_wb_fifo.sv | 53 +++++
 rtl/reg_writeback.sv | 106 ++++++++++
 tb/tb_reg_writeback.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared register-file constants and helpers for write-back
package reg_writeback_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hard-wired, so a pending write to it can never be forwarded
  function automatic logic addr_match(input reg_addr_t rd, input reg_addr_t addr);
    return (addr != ZERO_REG) && (rd == addr);
  endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// rtl/reg_writeback_wb_fifo.sv - in-order result FIFO exposing every entry by age
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] age_data [DEPTH],
  output logic [DEPTH-1:0] age_valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed through the valid bits
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Rotate storage into age order: index 0 is the oldest (head) entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_data[i]  = mem[rd_ptr[AW-1:0] + AW'(i)];
      age_valid[i] = ((AW+1)'(i) < count);
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - buffered register-file write initiator with read forwarding
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH + 2),
  localparam int AW   = $clog2(DEPTH),
  localparam int EW   = REG_ADDR_W + XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  hold,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3,
  output logic                  WE3,
  input  logic [REG_ADDR_W-1:0] fwd_a1,
  input  logic [REG_ADDR_W-1:0] fwd_a2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2,
  output logic [PW-1:0]         pending
);

  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic [EW-1:0] head;
  logic [EW-1:0] entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic          out_valid;

  // Writes to x0 are swallowed at the door so they never occupy a slot
  assign wb_ready = !fifo_full;
  assign push     = wb_valid && wb_ready && (wb_rd != ZERO_REG);
  assign pop      = !hold && !fifo_empty;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wdata     ({wb_rd, wb_data}),
    .pop       (pop),
    .rdata     (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .age_data  (entries),
    .age_valid (entry_valid)
  );

  // Output stage: freezes under hold, otherwise takes the FIFO head or goes idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
    end else if (!hold) begin
      out_valid <= !fifo_empty;
      if (!fifo_empty) begin
        A3  <= head[EW-1:XLEN];
        WD3 <= head[XLEN-1:0];
      end
    end
  end

  assign WE3     = out_valid && !hold;
  assign pending = PW'(fifo_count) + PW'(out_valid);

  // Forwarding: output stage is oldest, later FIFO entries override earlier ones
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (out_valid && addr_match(A3, fwd_a1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = WD3;
    end
    if (out_valid && addr_match(A3, fwd_a2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = WD3;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && addr_match(entries[i][EW-1:XLEN], fwd_a1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = entries[i][XLEN-1:0];
      end
      if (entry_valid[i] && addr_match(entries[i][EW-1:XLEN], fwd_a2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = entries[i][XLEN-1:0];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - scoreboard bench for reg_writeback
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        hold = 1'b0;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [4:0]  fwd_a1 = '0;
  logic [4:0]  fwd_a2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [1:0]  pending;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         sb[$];
  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        rand_phase = 1'b0;

  reg_writeback #(.XLEN(32), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .hold      (hold),
    .A3        (A3),
    .WD3       (WD3),
    .WE3       (WE3),
    .fwd_a1    (fwd_a1),
    .fwd_a2    (fwd_a2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-file stub committing on the edge that ends a WE3 cycle
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (WE3 && A3 != 5'd0) rf[A3] <= WD3;

  // Scoreboard: every write must match the oldest accepted nonzero-rd result
  always @(negedge clk) begin
    if (WE3) begin
      if (sb.size() == 0) begin
        check("unexpected_we", {27'd0, A3}, 64'hFFFF);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wr_rd", {59'd0, A3}, {59'd0, e.rd});
        check("wr_data", {32'd0, WD3}, {32'd0, e.data});
      end
    end
  end

  always @(posedge clk) if (rand_phase) #1 hold = ($urandom_range(0, 2) == 0);

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    bit done = 0;
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (wb_ready) begin
        @(posedge clk);
        if (rd != 5'd0) sb.push_back('{rd: rd, data: data});
        done = 1;
      end
    end
    if (!done) check("push_timeout", 64'd0, 64'd1);
    #1 wb_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = (pending == 2'd0) && !WE3;
    end
    check({"idle_", tag}, {63'd0, idle}, 64'd1);
  endtask

  initial begin
    fwd_a1 = 5'd3;
    fwd_a2 = 5'd4;
    repeat (2) @(negedge clk);
    check("rst_A3", {59'd0, A3}, 64'd0);
    check("rst_WD3", {32'd0, WD3}, 64'd0);
    check("rst_WE3", {63'd0, WE3}, 64'd0);
    check("rst_pending", {62'd0, pending}, 64'd0);
    check("rst_ready", {63'd0, wb_ready}, 64'd1);
    check("rst_fwd", {fwd_hit1, fwd_hit2, fwd_data1 | fwd_data2}, 64'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Single write: latency of two edges, one-cycle WE3
    push(5'd15, 32'hABCDEF01);
    @(negedge clk);
    check("lat_we_n0", {63'd0, WE3}, 64'd0);
    @(negedge clk);
    check("lat_we_n1", {63'd0, WE3}, 64'd1);
    check("lat_A3", {59'd0, A3}, 64'd15);
    check("lat_WD3", {32'd0, WD3}, 64'hABCDEF01);
    @(negedge clk);
    check("lat_we_n2", {63'd0, WE3}, 64'd0);
    check("rf15", {32'd0, rf[15]}, 64'hABCDEF01);

    // x0 write is dropped entirely
    @(posedge clk); #1;
    push(5'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("x0_pending", {62'd0, pending}, 64'd0);
      check("x0_we", {63'd0, WE3}, 64'd0);
    end

    // Fill under hold: output stage + DEPTH entries, then a stalled fourth push
    @(posedge clk); #1;
    push(5'd1, 32'h11);
    @(posedge clk); #1 hold = 1'b1;
    push(5'd2, 32'h22);
    push(5'd3, 32'h33);
    fork
      push(5'd4, 32'h44);
      begin
        repeat (2) begin
          @(negedge clk);
          check("full_ready", {63'd0, wb_ready}, 64'd0);
          check("full_pending", {62'd0, pending}, 64'd3);
          check("full_we", {63'd0, WE3}, 64'd0);
        end
        @(posedge clk); #1 hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("drain_we", {63'd0, WE3}, 64'd1);
          check("drain_A3", {59'd0, A3}, 64'(i + 1));
        end
      end
    join
    wait_idle("fill");

    // Duplicate rd under hold: forwarding returns the newest value
    @(posedge clk); #1 hold = 1'b1;
    fwd_a1 = 5'd7;
    fwd_a2 = 5'd0;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    @(negedge clk);
    check("fwd_hit1", {63'd0, fwd_hit1}, 64'd1);
    check("fwd_data1", {32'd0, fwd_data1}, 64'hB);
    check("fwd_hit2_x0", {63'd0, fwd_hit2}, 64'd0);
    check("fwd_data2_x0", {32'd0, fwd_data2}, 64'd0);
    fwd_a2 = 5'd9;
    #1 check("fwd_miss", {63'd0, fwd_hit2}, 64'd0);
    fwd_a2 = 5'd7;
    #1 check("fwd_data2", {31'd0, fwd_hit2, fwd_data2}, {31'd0, 1'b1, 32'hB});
    @(posedge clk); #1 hold = 1'b0;
    wait_idle("dup");
    check("rf7", {32'd0, rf[7]}, 64'hB);
    check("fwd_after", {31'd0, fwd_hit1, fwd_data1}, 64'd0);

    // Reset while output stage and FIFO are loaded
    @(posedge clk); #1;
    push(5'd20, 32'h55);
    wait_idle("pre_rst");
    check("rf20_pre", {32'd0, rf[20]}, 64'h55);
    @(posedge clk); #1;
    push(5'd20, 32'hDEAD0001);
    @(posedge clk); #1 hold = 1'b1;
    push(5'd21, 32'hDEAD0002);
    push(5'd22, 32'hDEAD0003);
    @(negedge clk);
    #2 hold = 1'b0;
    #1 check("prerst_we", {63'd0, WE3}, 64'd1);
    reset = 1'b0;
    #1 check("rst_we_async", {63'd0, WE3}, 64'd0);
    check("rst_pending_async", {62'd0, pending}, 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rel_pending", {62'd0, pending}, 64'd0);
    check("rel_ready", {63'd0, wb_ready}, 64'd1);
    repeat (4) @(negedge clk);
    check("rf20_kept", {32'd0, rf[20]}, 64'h55);
    check("rf21_kept", {32'd0, rf[21]}, 64'd0);
    check("rf22_kept", {32'd0, rf[22]}, 64'd0);

    // Random traffic with random hold
    @(posedge clk); #1;
    rand_phase = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(5'($urandom_range(0, 31)), $urandom);
    end
    rand_phase = 1'b0;
    @(posedge clk); #2 hold = 1'b0;
    wait_idle("rand");
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
